// File: rtl/uart_tx_pkg.sv
// Shared UART definitions: system clock rate, width helper, bit-period rule, TX state encoding.
`default_nettype none

package uart_tx_pkg;

  localparam int CLK_FREQ = 50000000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_t;

  // Number of bits needed to hold 0..value-1 (never less than 1).
  function automatic int clogb2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    if (r == 0) r = 1;
    return r;
  endfunction

  function automatic int bit_period(input int baud);
    return CLK_FREQ / baud;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_baud_gen.sv
// Synchronous-reset bit-period counter: counts while enabled, wraps on its last count.
`default_nettype none

module uart_baud_gen
  import uart_tx_pkg::*;
#(
  parameter int cnt_max = 5208
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en,
  input  logic                        clr,
  output logic [clogb2(cnt_max)-1:0]  cnt,
  output logic                        cnt_end
);

  localparam int CNT_W = clogb2(cnt_max);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(cnt_max - 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n || clr || cnt_end) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cnt     = cnt_q;
  assign cnt_end = (cnt_q == CNT_LAST);

endmodule

`default_nettype wire

// File: rtl/uart_tx.sv
// UART transmitter: valid/ready word in, start bit + LSB-first data + one stop bit out on tx.
`default_nettype none

module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int datawidth = 5,
  parameter int Baudrate  = 9600
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [datawidth-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int cnt_max1 = bit_period(Baudrate);
  localparam int CNT_W    = clogb2(cnt_max1);
  localparam int IDX_W    = clogb2(datawidth + 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(datawidth - 1);

  tx_state_t              state_q;
  logic [datawidth-1:0]   shift_q;
  logic [datawidth-1:0]   shift_d;
  logic [IDX_W-1:0]       idx_q;
  logic                   tx_q;
  logic                   ready_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   baud_end;
  logic [CNT_W-1:0]       baud_cnt_unused;

  uart_baud_gen #(
    .cnt_max (cnt_max1)
  ) u_baud (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (busy_q),
    .clr     (state_q == ST_IDLE),
    .cnt     (baud_cnt_unused),
    .cnt_end (baud_end)
  );

  assign shift_d = shift_q >> 1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      tx_q    <= 1'b1;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (tx_valid && ready_q) begin
            state_q <= ST_START;
            shift_q <= tx_data;
            tx_q    <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        ST_START: begin
          if (baud_end) begin
            state_q <= ST_DATA;
            idx_q   <= '0;
            tx_q    <= shift_q[0];
          end
        end
        ST_DATA: begin
          if (baud_end) begin
            if (idx_q == IDX_LAST) begin
              state_q <= ST_STOP;
              tx_q    <= 1'b1;
            end else begin
              shift_q <= shift_d;
              tx_q    <= shift_d[0];
              idx_q   <= idx_q + 1'b1;
            end
          end
        end
        ST_STOP: begin
          // Ready rises with done so a held tx_valid restarts after one idle clock.
          if (baud_end) begin
            state_q <= ST_IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign tx       = tx_q;
  assign tx_ready = ready_q;
  assign tx_busy  = busy_q;
  assign tx_done  = done_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx against a frame-level line model and a mid-bit sampling receiver.
`default_nettype none

module tb_uart_tx;

  localparam int DW    = 5;
  localparam int BAUD  = 115200;
  localparam int CNT   = 50000000 / BAUD;
  localparam int FRAME = (DW + 2) * CNT;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] tx_data = '0;
  logic          tx_valid = 1'b0;
  logic          tx_ready;
  logic          tx;
  logic          tx_busy;
  logic          tx_done;

  int checks = 0;
  int errors = 0;

  always #10 clk = ~clk;

  uart_tx #(
    .datawidth (DW),
    .Baudrate  (BAUD)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx       (tx),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] got_vec();
    return {tx, tx_busy, tx_ready, tx_done};
  endfunction

  // Expected {tx, busy, ready, done} at clock i after the accepting edge.
  function automatic logic [3:0] exp_vec(input logic [DW-1:0] d, input int i);
    int slot;
    logic b;
    slot = i / CNT;
    if (i >= FRAME) return (i == FRAME) ? 4'b1011 : 4'b1010;
    if (slot == 0)       b = 1'b0;
    else if (slot <= DW) b = d[slot-1];
    else                 b = 1'b1;
    return {b, 3'b100};
  endfunction

  task automatic test_reset();
    rst_n    = 1'b0;
    tx_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tx_data = DW'($urandom);
      step();
      checks++;
      if (got_vec() !== 4'b1010) begin
        errors++;
        $display("FAIL reset_hold c=%0d got %b exp 1010", c, got_vec());
      end
    end
    tx_valid = 1'b0;
    rst_n    = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      checks++;
      if (got_vec() !== 4'b1010) begin
        errors++;
        $display("FAIL reset_release c=%0d got %b exp 1010", c, got_vec());
      end
    end
  endtask

  task automatic test_single_frame();
    logic [DW-1:0] d;
    int done_at;
    int done_cnt;
    d        = 5'b10110;
    done_at  = -1;
    done_cnt = 0;
    tx_valid = 1'b1;
    tx_data  = d;
    step();
    tx_valid = 1'b0;
    for (int i = 0; i <= FRAME + 5; i++) begin
      checks++;
      if (got_vec() !== exp_vec(d, i)) begin
        errors++;
        $display("FAIL single_frame i=%0d got %b exp %b", i, got_vec(), exp_vec(d, i));
      end
      if (tx_done === 1'b1) begin
        done_cnt++;
        if (done_at < 0) done_at = i;
      end
      if (i < FRAME + 5) begin
        tx_data = DW'($urandom);
        step();
      end
    end
    checks++;
    if (done_at !== 3038 || done_cnt !== 1) begin
      errors++;
      $display("FAIL single_frame_len done_at=%0d count=%0d exp 3038 count 1", done_at, done_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] w [3];
    logic [DW-1:0] rx;
    w[0] = 5'b00000;
    w[1] = 5'b11111;
    w[2] = 5'b01010;
    tx_valid = 1'b1;
    tx_data  = w[0];
    for (int f = 0; f < 3; f++) begin
      step();
      if (f < 2) tx_data = w[f+1];
      else       tx_valid = 1'b0;
      rx = '0;
      for (int i = 0; i <= FRAME; i++) begin
        checks++;
        if (got_vec() !== exp_vec(w[f], i)) begin
          errors++;
          $display("FAIL b2b f=%0d i=%0d got %b exp %b", f, i, got_vec(), exp_vec(w[f], i));
        end
        for (int s = 1; s <= DW; s++) begin
          if (i == s * CNT + CNT / 2) rx[s-1] = tx;
        end
        if (i < FRAME) step();
      end
      checks++;
      if (rx !== w[f]) begin
        errors++;
        $display("FAIL b2b_rx f=%0d got %b exp %b", f, rx, w[f]);
      end
    end
    step();
    checks++;
    if (got_vec() !== 4'b1010) begin
      errors++;
      $display("FAIL b2b_tail got %b exp 1010", got_vec());
    end
  endtask

  task automatic test_busy_ignore();
    logic [DW-1:0] d;
    d        = 5'b00001;
    tx_valid = 1'b1;
    tx_data  = d;
    step();
    tx_valid = 1'b0;
    for (int i = 0; i <= FRAME + 2 * CNT; i++) begin
      checks++;
      if (got_vec() !== exp_vec(d, i)) begin
        errors++;
        $display("FAIL busy_ignore i=%0d got %b exp %b", i, got_vec(), exp_vec(d, i));
      end
      if (i == 2 * CNT) begin
        tx_valid = 1'b1;
        tx_data  = 5'b11111;
      end else begin
        tx_valid = 1'b0;
      end
      step();
    end
  endtask

  task automatic test_mid_reset();
    logic [DW-1:0] d;
    int stop_i;
    d        = DW'($urandom);
    stop_i   = 3 * CNT + CNT / 2;
    tx_valid = 1'b1;
    tx_data  = d;
    step();
    tx_valid = 1'b0;
    for (int i = 0; i <= stop_i; i++) begin
      checks++;
      if (got_vec() !== exp_vec(d, i)) begin
        errors++;
        $display("FAIL mid_reset_pre i=%0d got %b exp %b", i, got_vec(), exp_vec(d, i));
      end
      if (i < stop_i) step();
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    checks++;
    if (got_vec() !== 4'b1010) begin
      errors++;
      $display("FAIL mid_reset_edge got %b exp 1010", got_vec());
    end
    for (int c = 0; c < 2 * CNT; c++) begin
      step();
      checks++;
      if (got_vec() !== 4'b1010) begin
        errors++;
        $display("FAIL mid_reset_idle c=%0d got %b exp 1010", c, got_vec());
      end
    end
  endtask

  task automatic test_random_frames();
    logic [DW-1:0] d;
    logic [DW-1:0] rx;
    for (int f = 0; f < 4; f++) begin
      d = DW'($urandom);
      repeat ($urandom_range(0, 5)) step();
      tx_valid = 1'b1;
      tx_data  = d;
      step();
      tx_valid = 1'b0;
      rx = '0;
      for (int i = 0; i <= FRAME; i++) begin
        checks++;
        if (got_vec() !== exp_vec(d, i)) begin
          errors++;
          $display("FAIL random f=%0d i=%0d got %b exp %b", f, i, got_vec(), exp_vec(d, i));
        end
        for (int s = 1; s <= DW; s++) begin
          if (i == s * CNT + CNT / 2) rx[s-1] = tx;
        end
        if (i < FRAME) begin
          tx_data = DW'($urandom);
          step();
        end
      end
      checks++;
      if (rx !== d) begin
        errors++;
        $display("FAIL random_rx f=%0d got %b exp %b", f, rx, d);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_busy_ignore();
    test_mid_reset();
    test_random_frames();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
